// File: rtl/hvac_pkg.sv
// Shared types and default timing for the HVAC actuator sequencer.
package hvac_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_FAN_PRE  = 2'b01,
    ST_RUN      = 2'b10,
    ST_FAN_POST = 2'b11
  } state_e;

  typedef enum logic {
    MODE_HEAT = 1'b0,
    MODE_COOL = 1'b1
  } mode_e;

  localparam int unsigned DEF_CNT_W        = 24;
  localparam int unsigned DEF_FAN_PRE_CYC  = 4;
  localparam int unsigned DEF_MIN_ON_CYC   = 10;
  localparam int unsigned DEF_FAN_POST_CYC = 3;
  localparam int unsigned DEF_MIN_OFF_CYC  = 20;

endpackage

// File: rtl/hvac_down_timer.sv
// Loadable down-counter that saturates at zero; used for phase timing and compressor hold-off.
module hvac_down_timer #(
  parameter int unsigned CNT_W = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic [CNT_W-1:0] reset_val,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Load takes priority; otherwise count down and hold at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Counter register; reset value is tied off by the instantiating block.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= reset_val;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/hvac_actuator_sequencer.sv
// Sequences fan, heater and compressor from thermostat heat/cool demands with purge and protection timing.
module hvac_actuator_sequencer
  import hvac_pkg::*;
#(
  parameter int unsigned CNT_W        = DEF_CNT_W,
  parameter int unsigned FAN_PRE_CYC  = DEF_FAN_PRE_CYC,
  parameter int unsigned MIN_ON_CYC   = DEF_MIN_ON_CYC,
  parameter int unsigned FAN_POST_CYC = DEF_FAN_POST_CYC,
  parameter int unsigned MIN_OFF_CYC  = DEF_MIN_OFF_CYC
) (
  input  logic clk,
  input  logic reset,
  input  logic heating,
  input  logic cooling,
  output logic fan_en,
  output logic heater_en,
  output logic compressor_en,
  output logic cool_blocked,
  output logic conflict,
  output logic busy
);

  state_e state_q, state_d;
  mode_e  mode_q, mode_d;

  logic req_h, req_c, req_mode;
  logic done, comp_ready;
  logic tmr_load;
  logic [CNT_W-1:0] tmr_val;
  logic holdoff_load;

  logic fan_q, heater_q, comp_q, blocked_q, conflict_q;
  logic fan_d, heater_d, comp_d, blocked_d, conflict_d;

  // Simultaneous heat and cool demand is treated as no demand.
  assign req_h    = heating & ~cooling;
  assign req_c    = cooling & ~heating;
  assign req_mode = (mode_q == MODE_COOL) ? req_c : req_h;

  // Next-state, timer reload and registered-output next values.
  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    tmr_load = 1'b0;
    tmr_val  = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (req_h) begin
          state_d = ST_FAN_PRE;
          mode_d  = MODE_HEAT;
        end else if (req_c && comp_ready) begin
          state_d = ST_FAN_PRE;
          mode_d  = MODE_COOL;
        end
      end
      ST_FAN_PRE: begin
        if (!req_mode) begin
          state_d = ST_FAN_POST;
        end else if (done) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (done && !req_mode) begin
          state_d = ST_FAN_POST;
        end
      end
      ST_FAN_POST: begin
        if (done) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Every phase change restarts the phase timer at (duration - 1).
    if (state_d != state_q) begin
      tmr_load = 1'b1;
      unique case (state_d)
        ST_FAN_PRE:  tmr_val = CNT_W'(FAN_PRE_CYC - 1);
        ST_RUN:      tmr_val = CNT_W'(MIN_ON_CYC - 1);
        ST_FAN_POST: tmr_val = CNT_W'(FAN_POST_CYC - 1);
        default:     tmr_val = '0;
      endcase
    end

    fan_d      = (state_d != ST_IDLE);
    heater_d   = (state_d == ST_RUN) && (mode_d == MODE_HEAT);
    comp_d     = (state_d == ST_RUN) && (mode_d == MODE_COOL);
    blocked_d  = (state_q == ST_IDLE) && req_c && !comp_ready;
    conflict_d = heating & cooling;
  end

  // Hold-off restarts on the edge where the compressor drops.
  assign holdoff_load = comp_q & ~comp_d;

  // State, mode and all outputs share one register stage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      mode_q     <= MODE_HEAT;
      fan_q      <= 1'b0;
      heater_q   <= 1'b0;
      comp_q     <= 1'b0;
      blocked_q  <= 1'b0;
      conflict_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      fan_q      <= fan_d;
      heater_q   <= heater_d;
      comp_q     <= comp_d;
      blocked_q  <= blocked_d;
      conflict_q <= conflict_d;
    end
  end

  hvac_down_timer #(.CNT_W(CNT_W)) u_state_timer (
    .clk       (clk),
    .reset     (reset),
    .load      (tmr_load),
    .load_val  (tmr_val),
    .reset_val ('0),
    .zero      (done)
  );

  // Starts loaded so the compressor is protected from power-up.
  hvac_down_timer #(.CNT_W(CNT_W)) u_holdoff_timer (
    .clk       (clk),
    .reset     (reset),
    .load      (holdoff_load),
    .load_val  (CNT_W'(MIN_OFF_CYC)),
    .reset_val (CNT_W'(MIN_OFF_CYC)),
    .zero      (comp_ready)
  );

  assign fan_en        = fan_q;
  assign heater_en     = heater_q;
  assign compressor_en = comp_q;
  assign cool_blocked  = blocked_q;
  assign conflict      = conflict_q;
  assign busy          = fan_q;

endmodule

// File: tb/tb_hvac_actuator_sequencer.sv
// Self-checking bench for hvac_actuator_sequencer: vector table, directed corner cases, random run vs model.
module tb_hvac_actuator_sequencer;
  import hvac_pkg::*;

  localparam int PRE  = 4;
  localparam int ON   = 10;
  localparam int POST = 3;
  localparam int OFF  = 20;

  logic clk, reset, heating, cooling;
  logic fan_en, heater_en, compressor_en, cool_blocked, conflict, busy;

  int total = 0;
  int bad   = 0;

  hvac_actuator_sequencer #(
    .CNT_W(24), .FAN_PRE_CYC(PRE), .MIN_ON_CYC(ON),
    .FAN_POST_CYC(POST), .MIN_OFF_CYC(OFF)
  ) dut (
    .clk(clk), .reset(reset), .heating(heating), .cooling(cooling),
    .fan_en(fan_en), .heater_en(heater_en), .compressor_en(compressor_en),
    .cool_blocked(cool_blocked), .conflict(conflict), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: phase number plus timestamps of phase entry and compressor stop.
  int       m_ph, m_ent, m_now, m_toff;
  bit       m_cool;
  bit [5:0] m_out;

  function automatic int dur(input int ph);
    case (ph)
      1: return PRE;
      2: return ON;
      3: return POST;
      default: return 0;
    endcase
  endfunction

  function automatic void model_reset();
    m_ph = 0; m_cool = 0; m_now = 0; m_ent = 0; m_toff = 0; m_out = '0;
  endfunction

  function automatic void model_step(input bit h, input bit c);
    int n, nph;
    bit rh, rc, rq, ready, done, blocked, old_comp, new_comp;
    n        = m_now + 1;
    rh       = h & ~c;
    rc       = c & ~h;
    ready    = (n - 1 - m_toff) >= OFF;
    rq       = m_cool ? rc : rh;
    done     = (n - m_ent) >= dur(m_ph);
    blocked  = (m_ph == 0) && rc && !ready;
    old_comp = (m_ph == 2) && m_cool;
    nph      = m_ph;
    case (m_ph)
      0: if (rh) begin nph = 1; m_cool = 0; end
         else if (rc && ready) begin nph = 1; m_cool = 1; end
      1: if (!rq) nph = 3; else if (done) nph = 2;
      2: if (done && !rq) nph = 3;
      default: if (done) nph = 0;
    endcase
    if (nph != m_ph) m_ent = n;
    m_ph     = nph;
    new_comp = (m_ph == 2) && m_cool;
    if (old_comp && !new_comp) m_toff = n;
    m_now = n;
    m_out = {m_ph != 0, (m_ph == 2) && !m_cool, new_comp, blocked, h & c, m_ph != 0};
  endfunction

  function automatic logic [5:0] dutv();
    return {fan_en, heater_en, compressor_en, cool_blocked, conflict, busy};
  endfunction

  task automatic chk(input string nm, input logic [5:0] got, input logic [5:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%b exp=%b t=%0t", nm, got, exp, $time);
    end
  endtask

  task automatic tick(input bit h, input bit c);
    heating = h;
    cooling = c;
    @(posedge clk);
    model_step(h, c);
    #1;
  endtask

  task automatic do_reset(input bit h, input bit c);
    heating = h;
    cooling = c;
    reset   = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_state", dutv(), 6'b0);
    reset = 1'b0;
    model_reset();
  endtask

  // Cooling held from reset release: blocked for OFF cycles, then pre-purge, then compressor.
  task automatic powerup_cool(input string tag);
    for (int n = 1; n <= OFF; n++) begin
      tick(0, 1);
      chk({tag, "_blocked"}, {5'b0, cool_blocked}, 6'd1);
      chk({tag, "_fan_off"}, {5'b0, fan_en}, 6'd0);
    end
    tick(0, 1);
    chk({tag, "_prepurge"}, {fan_en, cool_blocked}, 6'b10);
    for (int n = OFF + 2; n < OFF + 1 + PRE; n++) begin
      tick(0, 1);
      chk({tag, "_comp_wait"}, {5'b0, compressor_en}, 6'd0);
    end
    tick(0, 1);
    chk({tag, "_comp_on"}, {5'b0, compressor_en}, 6'd1);
  endtask

  typedef struct {
    bit       h;
    bit       c;
    bit [5:0] exp;
  } vec_t;

  vec_t tbl[19];

  initial begin
    bit h, c, fell;
    reset = 1'b1; heating = 1'b0; cooling = 1'b0;
    model_reset();

    // Heat cycle table: demand for edges 1..6, heater on edges 5..14, fan off at 18.
    for (int i = 0; i < 19; i++) begin
      int n;
      bit f, ht;
      n  = i + 1;
      f  = (n <= 17);
      ht = (n >= 5) && (n <= 14);
      tbl[i].h   = (n <= 6);
      tbl[i].c   = 1'b0;
      tbl[i].exp = {f, ht, 1'b0, 1'b0, 1'b0, f};
    end
    do_reset(0, 0);
    for (int i = 0; i < 19; i++) begin
      tick(tbl[i].h, tbl[i].c);
      chk($sformatf("heat_tbl_e%0d", i + 1), dutv(), tbl[i].exp);
    end

    // Power-up hold-off, then short-cycle protection after the compressor stops.
    do_reset(0, 1);
    powerup_cool("pwrup");
    for (int n = OFF + PRE + 2; n <= 40; n++) tick(0, 1);
    fell = 0;
    for (int k = 0; k < 30 && !fell; k++) begin
      tick(0, 0);
      fell = !compressor_en;
    end
    chk("comp_fall_seen", {5'b0, fell}, 6'd1);
    tick(0, 0); tick(0, 0);
    chk("post_fan_e2", {5'b0, fan_en}, 6'd1);
    tick(0, 0);
    chk("post_fan_e3", {5'b0, fan_en}, 6'd0);
    tick(0, 0);
    tick(0, 1);
    chk("short_blocked", {5'b0, cool_blocked}, 6'd1);
    for (int n = 6; n <= OFF + PRE; n++) begin
      tick(0, 1);
      chk("short_comp_hold", {5'b0, compressor_en}, 6'd0);
    end
    tick(0, 1);
    chk("short_comp_on", {5'b0, compressor_en}, 6'd1);

    // Conflict in IDLE, then conflict during RUN(HEAT) past min-on.
    do_reset(0, 0);
    for (int n = 0; n < 3; n++) begin
      tick(1, 1);
      chk("conflict_idle", dutv(), 6'b000010);
    end
    do_reset(0, 0);
    for (int n = 1; n <= 16; n++) tick(1, 0);
    chk("heat_run", {heater_en, fan_en}, 6'b11);
    tick(1, 1);
    chk("conflict_run", dutv(), 6'b100011);

    // Abort during pre-purge.
    do_reset(0, 0);
    tick(1, 0); tick(1, 0);
    tick(0, 0);
    chk("abort_post", dutv(), 6'b100001);
    tick(0, 0); tick(0, 0);
    chk("abort_post_end", {heater_en, fan_en}, 6'b01);
    tick(0, 0);
    chk("abort_idle", dutv(), 6'b0);

    // Asynchronous reset mid-RUN, then power-up protection again.
    do_reset(0, 0);
    for (int n = 1; n <= 8; n++) tick(1, 0);
    chk("pre_rst_run", {5'b0, heater_en}, 6'd1);
    #2 reset = 1'b1;
    #1 chk("async_rst_mid_run", dutv(), 6'b0);
    do_reset(0, 1);
    powerup_cool("after_rst");

    // Random demand run against the reference model, with occasional async resets.
    do_reset(0, 0);
    h = 0; c = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 11) == 0) h = ~h;
      if ($urandom_range(0, 11) == 0) c = ~c;
      tick(h, c);
      chk($sformatf("rand_%0d", i), dutv(), m_out);
      if ($urandom_range(0, 499) == 0) begin
        #2 reset = 1'b1;
        #1 chk("rand_async_rst", dutv(), 6'b0);
        do_reset(h, c);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
